// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit: main control FSM for the multicycle MIPS datapath.
// Optional retired-instruction counter enabled by defining INSTR_COUNTER_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_control_unit #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       IllegalOp,
  output logic [3:0] State
`ifdef INSTR_COUNTER_EN
  ,
  output logic [COUNTER_WIDTH-1:0] InstrCount
`endif
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_WB_R      = 4'd7;
  localparam logic [3:0] S_EXEC_I    = 4'd8;
  localparam logic [3:0] S_WB_I      = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_JUMP      = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_LUI = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_R   = 3'b111;

  logic [3:0] state;
  logic [3:0] state_next;
  logic [5:0] op_latched;

  // State register; the opcode is captured on the edge leaving DECODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      op_latched <= 6'b000000;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        op_latched <= Opcode;
      end
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:              state_next = S_MEM_ADDR;
          OP_R:                      state_next = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_LUI:   state_next = S_EXEC_I;
          OP_BEQ:                    state_next = S_BRANCH;
          OP_J:                      state_next = S_JUMP;
          default:                   state_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_next = (op_latched == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: state_next = S_MEM_WB;
      S_EXEC_R:   state_next = S_WB_R;
      S_EXEC_I:   state_next = S_WB_I;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    MemtoReg  = 1'b0;
    RegDst    = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSource  = 2'b00;
    ALUOp     = 3'b000;
    IllegalOp = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
        PCWrite = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = ALU_ADD;
        case (Opcode)
          OP_LW, OP_SW, OP_R, OP_ADDI, OP_ORI, OP_LUI, OP_BEQ, OP_J: IllegalOp = 1'b0;
          default: IllegalOp = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = ALU_ADD;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_R;
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (op_latched)
          OP_ORI:  ALUOp = ALU_OR;
          OP_LUI:  ALUOp = ALU_LUI;
          default: ALUOp = ALU_ADD;
        endcase
      end
      S_WB_I: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = 2'b01;
        PCWrite  = Zero;  // the only Mealy term
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign State = state;

`ifdef INSTR_COUNTER_EN
  logic [COUNTER_WIDTH-1:0] instr_count;
  logic                     retire;

  // Every terminal state of a legal instruction returns to FETCH next.
  assign retire = (state == S_MEM_WB) || (state == S_MEM_WRITE) || (state == S_WB_R) ||
                  (state == S_WB_I)   || (state == S_BRANCH)    || (state == S_JUMP);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= '0;
    end else if (retire) begin
      instr_count <= instr_count + 1'b1;
    end
  end

  assign InstrCount = instr_count;
`else
  if (COUNTER_WIDTH < 1) begin : g_no_counter
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: vector table, hand-written
// corner sequences and randomized instructions against an instruction-level model.
`default_nettype none

module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       Zero;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite;
  logic       ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] State;
`ifdef INSTR_COUNTER_EN
  logic [31:0] InstrCount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control_unit #(.COUNTER_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
    .IllegalOp(IllegalOp), .State(State)
`ifdef INSTR_COUNTER_EN
    , .InstrCount(InstrCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packed control word: {pcw,iord,mr,mw,irw,m2r,rdst,rw,asa,asb,pcs,aop,ill,state}
  function automatic logic [20:0] mk(input logic pcw, iord, mr, mw, irw, m2r, rdst, rw, asa,
                                     input logic [1:0] asb, input logic [1:0] pcs,
                                     input logic [2:0] aop, input logic ill, input logic [3:0] st);
    return {pcw, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, pcs, aop, ill, st};
  endfunction

  function automatic logic [20:0] dut_word();
    return {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
            ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp, State};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'o00, 6'o02, 6'o04, 6'o10, 6'o15, 6'o17, 6'o43, 6'o53};
  endfunction

  // Cycles per instruction including FETCH.
  function automatic int cpi(input logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000, 6'b001101, 6'b001111: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  // Expected control word for step k of an instruction (k=0 is FETCH).
  function automatic logic [20:0] model(input logic [5:0] op, input int k, input logic z);
    logic [2:0] iop;
    if (k == 0) return mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b100,0,4'd0);
    if (k == 1) return mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b100,!is_legal(op),4'd1);
    iop = (op == 6'b001101) ? 3'b001 : (op == 6'b001111) ? 3'b101 : 3'b100;
    case (op)
      6'b100011: begin
        if (k == 2) return mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b100,0,4'd2);
        if (k == 3) return mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0,4'd3);
        return mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0,4'd4);
      end
      6'b101011: begin
        if (k == 2) return mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b100,0,4'd2);
        return mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,0,4'd5);
      end
      6'b000000: begin
        if (k == 2) return mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111,0,4'd6);
        return mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0,4'd7);
      end
      6'b001000, 6'b001101, 6'b001111: begin
        if (k == 2) return mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,iop,0,4'd8);
        return mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0,4'd9);
      end
      6'b000100: return mk(z,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b010,0,4'd10);
      6'b000010: return mk(1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0,4'd11);
      default:   return '0;
    endcase
  endfunction

  // Runs one instruction from FETCH, comparing every cycle against the model.
  // Entered and left 1ns after a rising edge with the DUT in FETCH.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic z);
    Opcode = op;
    Zero   = z;
    for (int k = 0; k < cpi(op); k++) begin
      @(negedge clk);
      check($sformatf("%s_step%0d", tag, k), {11'd0, dut_word()}, {11'd0, model(op, k, z)});
      if (MemRead && MemWrite) check({tag, "_mem_excl"}, 1, 0);
      if (PCWrite && RegWrite) check({tag, "_wr_excl"}, 1, 0);
      @(posedge clk);
      #1;
      if (k == 1) Opcode = 6'($urandom);
    end
    check({tag, "_back_to_fetch"}, {28'd0, State}, 32'd0);
  endtask

  typedef struct {
    logic [5:0] op;
    logic       zero;
    int         cycles;
    logic [3:0] key_st;
    logic [2:0] key_aluop;
    logic       key_pcw;
    logic [1:0] key_pcs;
    logic       ill;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input int idx);
    int         cyc;
    logic [2:0] aop;
    logic       pcw, ill, seen;
    logic [1:0] pcs;
    vec_t v;
    v = vecs[idx];
    Opcode = v.op;
    Zero   = v.zero;
    cyc = 0; ill = 0; seen = 0; aop = '0; pcw = 0; pcs = '0;
    do begin
      @(negedge clk);
      if (State == v.key_st && !seen) begin
        seen = 1; aop = ALUOp; pcw = PCWrite; pcs = PCSource;
      end
      if (State == 4'd1) ill = ill | IllegalOp;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 2) Opcode = 6'($urandom);
    end while (State != 4'd0 && cyc < 12);
    check($sformatf("vec%0d_cycles", idx), cyc, v.cycles);
    check($sformatf("vec%0d_key_seen", idx), {31'd0, seen}, 32'd1);
    check($sformatf("vec%0d_aluop", idx), {29'd0, aop}, {29'd0, v.key_aluop});
    check($sformatf("vec%0d_pcwrite", idx), {31'd0, pcw}, {31'd0, v.key_pcw});
    check($sformatf("vec%0d_pcsource", idx), {30'd0, pcs}, {30'd0, v.key_pcs});
    check($sformatf("vec%0d_illegal", idx), {31'd0, ill}, {31'd0, v.ill});
  endtask

  logic [5:0] legal_ops[8] = '{6'o00, 6'o02, 6'o04, 6'o10, 6'o15, 6'o17, 6'o43, 6'o53};

  initial begin
    int guard;
    logic [5:0] rop;

    vecs[0]  = '{6'b000000, 1'b0, 4,  4'd6, 3'b111, 1'b0, 2'b00, 1'b0};
    vecs[1]  = '{6'b100011, 1'b0, 5,  4'd3, 3'b000, 1'b0, 2'b00, 1'b0};
    vecs[2]  = '{6'b101011, 1'b0, 4,  4'd5, 3'b000, 1'b0, 2'b00, 1'b0};
    vecs[3]  = '{6'b001000, 1'b0, 4,  4'd8, 3'b100, 1'b0, 2'b00, 1'b0};
    vecs[4]  = '{6'b001101, 1'b0, 4,  4'd8, 3'b001, 1'b0, 2'b00, 1'b0};
    vecs[5]  = '{6'b001111, 1'b0, 4,  4'd8, 3'b101, 1'b0, 2'b00, 1'b0};
    vecs[6]  = '{6'b000100, 1'b1, 3, 4'd10, 3'b010, 1'b1, 2'b01, 1'b0};
    vecs[7]  = '{6'b000100, 1'b0, 3, 4'd10, 3'b010, 1'b0, 2'b01, 1'b0};
    vecs[8]  = '{6'b000010, 1'b0, 3, 4'd11, 3'b000, 1'b1, 2'b10, 1'b0};
    vecs[9]  = '{6'b111111, 1'b0, 2,  4'd1, 3'b100, 1'b0, 2'b00, 1'b1};
    vecs[10] = '{6'b000001, 1'b0, 2,  4'd1, 3'b100, 1'b0, 2'b00, 1'b1};

    // Reset held three cycles; outputs show the FETCH decode throughout.
    reset  = 1'b1;
    Opcode = 6'b111111;
    Zero   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check($sformatf("reset_word%0d", i), {11'd0, dut_word()}, {11'd0, model(6'd0, 0, 1'b0)});
    end
    @(posedge clk);
    #1;
`ifdef INSTR_COUNTER_EN
    check("count_after_reset", InstrCount, 32'd0);
`endif
    reset = 1'b0;
    run_instr("first_r", 6'b000000, 1'b0);

    for (int i = 0; i < 11; i++) run_vec(i);

    // Hand sequences: full per-cycle checks on key instructions.
    run_instr("lw", 6'b100011, 1'b0);
    run_instr("sw", 6'b101011, 1'b0);
    run_instr("beq_z1", 6'b000100, 1'b1);
    run_instr("beq_z0", 6'b000100, 1'b0);
    run_instr("illegal", 6'b111111, 1'b0);

    // Reset while in MEM_READ aborts the instruction.
    Opcode = 6'b100011;
    guard = 0;
    while (State != 4'd3 && guard < 10) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("reach_mem_read", {28'd0, State}, 32'd3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_instr", {28'd0, State}, 32'd0);
    reset  = 1'b0;
    Opcode = 6'b000000;
    run_instr("after_abort", 6'b000000, 1'b0);

`ifdef INSTR_COUNTER_EN
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("count_zero", InstrCount, 32'd0);
    run_instr("cnt_r", 6'b000000, 1'b0);
    run_instr("cnt_lw", 6'b100011, 1'b0);
    run_instr("cnt_sw", 6'b101011, 1'b0);
    run_instr("cnt_ill", 6'b111110, 1'b0);
    run_instr("cnt_j", 6'b000010, 1'b0);
    check("count_four", InstrCount, 32'd4);
`endif

    // Randomized instruction stream.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) rop = 6'($urandom);
      else rop = legal_ops[$urandom_range(0, 7)];
      run_instr($sformatf("rand%0d", i), rop, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end, expected end");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Main control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU control decoder. It sequences fetch, decode, execute, memory and write-back for the supported instructions. It drives the 3-bit ALUOp and all datapath enables/selects from the instruction opcode and the ALU Zero flag.

Parameters:
COUNTER_WIDTH, 32, width of retired-instruction counter (used only when INSTR_COUNTER_EN is defined)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous reset, active-high
Opcode  input  6  instruction bits [31:26] from IR
Zero  input  1  ALU zero flag
PCWrite  output  1  PC register load enable
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
MemtoReg  output  1  register write data: 0=ALUOut, 1=MDR
RegDst  output  1  destination register: 0=rt, 1=rd
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A: 0=PC, 1=rs
ALUSrcB  output  2  ALU B: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
PCSource  output  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
ALUOp  output  3  to ALU control: 111 R-type, 100 add, 001 or, 101 lui, 010 subtract
IllegalOp  output  1  one-cycle pulse on unsupported opcode
State  output  4  current state code (debug)

Behaviour:
- Moore FSM, state register updated on rising clk; outputs are combinational decode of the registered state. The one Mealy term is PCWrite in BRANCH.
- reset=1 at an edge: state<=FETCH, latched opcode<=000000. Reset dominates any transition, including mid-instruction. During and after reset all outputs equal the FETCH decode; IllegalOp=0.
- States and codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, WB_R 7, EXEC_I 8, WB_I 9, BRANCH 10, JUMP 11. Codes 12–15 go to FETCH on the next edge with all outputs 0.
- Any output not listed for a state is 0.
- FETCH: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=100. Latch Opcode into an internal register; all later states use the latched copy. Next state by opcode:
  - 100011 (LW) or 101011 (SW): MEM_ADDR
  - 000000 (R): EXEC_R
  - 001000 (ADDI), 001101 (ORI), 001111 (LUI): EXEC_I
  - 000100 (BEQ): BRANCH
  - 000010 (J): JUMP
  - any other opcode: FETCH, with IllegalOp=1 for exactly that DECODE cycle.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=100. Next state is MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: MemRead=1, IorD=1. Next state is MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Next state is FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Next state is FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111. Next state is WB_R.
- WB_R: RegWrite=1, RegDst=1, MemtoReg=0. Next state is FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10. ALUOp is 100 for ADDI, 001 for ORI, 101 for LUI. Next state is WB_I.
- WB_I: RegWrite=1, RegDst=0, MemtoReg=0. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=010, PCSource=01, PCWrite=Zero. Next state is FETCH.
- JUMP: PCSource=10, PCWrite=1. Next state is FETCH.
- Cycles per instruction, counting FETCH: LW 5; SW, R-type, ADDI/ORI/LUI 4; BEQ, J 3; illegal opcode 2.
- Mutual exclusion: MemRead and MemWrite are never both 1. PCWrite and RegWrite are never both 1.
- Opcode changes outside DECODE have no effect.

Optional Feature:
INSTR_COUNTER_EN.
- Defined: adds output InstrCount [COUNTER_WIDTH-1:0].
  - Reset value 0.
  - Increments by 1 on each edge leaving MEM_WB, MEM_WRITE, WB_R, WB_I, BRANCH or JUMP.
  - Wraps from all-ones to 0.
  - Illegal opcodes are not counted.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset asserted 3 cycles, then released with Opcode=000000 -> State=0, PCWrite=1, IRWrite=1, ALUOp=100, ALUSrcB=01; State=1 on the next edge.
- R-type (Opcode=000000) -> State sequence 0,1,6,7,0. ALUOp=111 in state 6. RegWrite=1 and RegDst=1 only in state 7.
- LW (100011) then SW (101011) -> LW: 0,1,2,3,4 with MemRead=1 in states 0 and 3, MemtoReg=1 in 4. SW: 0,1,2,5 with MemWrite=1 only in 5.
- ORI (001101) -> ALUOp=001 in state 8. LUI (001111) -> ALUOp=101 in state 8. Change Opcode to 000000 during state 8 -> ALUOp stays at the latched value.
- BEQ (000100) with Zero=1 -> PCWrite=1 and PCSource=01 in state 10. Repeat with Zero=0 -> PCWrite=0. J (000010) -> PCWrite=1 and PCSource=10 in state 11.
- Opcode=111111 -> IllegalOp=1 for the one DECODE cycle, then State=0. Separately, reset asserted while in state 3 -> State=0 on the next edge. With INSTR_COUNTER_EN defined, InstrCount=0 after reset and 4 after R, LW, SW, J.
